// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage MIPS core pipeline registers:
//   - exception code constants carried down the pipe in *_ExcCode
//   - default Tnew field width and reset/handler PC values
//   - the packed payload struct latched by the D->E register
//   - the capture-mode enum that selects normal / bubble / flush behaviour
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Exception codes (CP0 Cause.ExcCode encoding).
  localparam logic [4:0] EXC_NONE    = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // Hazard timing field width.
  localparam int TNEW_W = 2;

  // PC defaults: reset vector and exception handler entry.
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  // What a pipeline register does on a given edge.
  typedef enum logic [1:0] {
    CAP_NORMAL = 2'd0,  // capture upstream stage
    CAP_BUBBLE = 2'd1,  // insert a bubble, keep PC/BD for precise interrupts
    CAP_FLUSH  = 2'd2   // exception/interrupt flush to handler
  } cap_mode_e;

  // Everything the D->E register carries except Tnew (whose width is a
  // per-instance parameter).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] ext_imm;
    logic [4:0]  write_reg;
    logic [4:0]  exc_code;
    logic        bd;
  } de_payload_t;

endpackage

// File: rtl/tnew_sat_dec.sv
// -----------------------------------------------------------------------------
// tnew_sat_dec
// Saturating decrement of a Tnew hazard-timing field: 0 stays 0, otherwise
// subtract one. Shared by the D->E, E->M and M->W pipeline registers.
// Ports:
//   tnew_i  in  W  Tnew as seen by the upstream stage
//   tnew_o  out W  Tnew one stage later, never below zero
// -----------------------------------------------------------------------------
module tnew_sat_dec #(
  parameter int W = 2
) (
  input  logic [W-1:0] tnew_i,
  output logic [W-1:0] tnew_o
);

  localparam logic [W-1:0] ONE = W'(1);

  assign tnew_o = (tnew_i == '0) ? '0 : (tnew_i - ONE);

endmodule

// File: rtl/de_pipe_reg.sv
// -----------------------------------------------------------------------------
// de_pipe_reg
// D->E pipeline register of the 5-stage MIPS core. Latches decoded operands,
// the resolved destination register, hazard timing (Tnew), exception state
// and the delay-slot flag. Inserts a bubble on a D-stage stall and clears
// itself on an exception/interrupt request. Priority: req > stall > normal.
// All outputs come straight from flops.
//
// Optional feature macro: DE_REG_VALID_EN adds output E_Valid (1 on a normal
// capture, 0 after reset/bubble/flush).
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   req                               flush request from CP0
//   stall                             D-stage stall from hazard unit
//   D_PC, D_Instr, D_RS_Data,
//   D_RT_Data, D_Ext_Imm      [31:0]  D-stage data
//   D_WriteReg [4:0], D_Tnew [TNEW_W-1:0], D_ExcCode [4:0], D_BD
//   E_*                               registered copies (E_Tnew = sat(D_Tnew-1))
//   E_Valid (DE_REG_VALID_EN only)    E holds a real instruction
// -----------------------------------------------------------------------------
module de_pipe_reg #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = cpu_pkg::HANDLER_PC_DEF,
  parameter int          TNEW_W     = cpu_pkg::TNEW_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              stall,
  input  logic [31:0]       D_PC,
  input  logic [31:0]       D_Instr,
  input  logic [31:0]       D_RS_Data,
  input  logic [31:0]       D_RT_Data,
  input  logic [31:0]       D_Ext_Imm,
  input  logic [4:0]        D_WriteReg,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic [4:0]        D_ExcCode,
  input  logic              D_BD,
  output logic [31:0]       E_PC,
  output logic [31:0]       E_Instr,
  output logic [31:0]       E_RS_Data,
  output logic [31:0]       E_RT_Data,
  output logic [31:0]       E_Ext_Imm,
  output logic [4:0]        E_WriteReg,
  output logic [TNEW_W-1:0] E_Tnew,
  output logic [4:0]        E_ExcCode,
  output logic              E_BD
`ifdef DE_REG_VALID_EN
  ,
  output logic              E_Valid
`endif
);

  import cpu_pkg::*;

  cap_mode_e          cap_mode;
  de_payload_t        pay_d, pay_q;
  logic [TNEW_W-1:0]  tnew_dec;
  logic [TNEW_W-1:0]  tnew_d, tnew_q;
`ifdef DE_REG_VALID_EN
  logic               valid_d, valid_q;
`endif

  tnew_sat_dec #(.W(TNEW_W)) u_tnew_dec (
    .tnew_i (D_Tnew),
    .tnew_o (tnew_dec)
  );

  // A flush outranks a stall: the bubble would otherwise leave the stalled
  // PC in E while CP0 is redirecting to the handler.
  always_comb begin
    if (req)        cap_mode = CAP_FLUSH;
    else if (stall) cap_mode = CAP_BUBBLE;
    else            cap_mode = CAP_NORMAL;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case below can infer a latch.
    pay_d  = '0;
    tnew_d = '0;
`ifdef DE_REG_VALID_EN
    valid_d = 1'b0;
`endif
    case (cap_mode)
      CAP_FLUSH: begin
        pay_d.pc = HANDLER_PC;
      end
      CAP_BUBBLE: begin
        // Keep PC and BD so an interrupt taken on the bubble still
        // produces the correct EPC and Cause.BD. WriteReg stays 0 so
        // forwarding/stall logic sees no producer.
        pay_d.pc = D_PC;
        pay_d.bd = D_BD;
      end
      CAP_NORMAL: begin
        pay_d.pc        = D_PC;
        pay_d.instr     = D_Instr;
        pay_d.rs_data   = D_RS_Data;
        pay_d.rt_data   = D_RT_Data;
        pay_d.ext_imm   = D_Ext_Imm;
        pay_d.write_reg = D_WriteReg;
        pay_d.exc_code  = D_ExcCode;
        pay_d.bd        = D_BD;
        tnew_d          = tnew_dec;
`ifdef DE_REG_VALID_EN
        valid_d         = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples its _d value from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this is a bank of individual flops, not a memory, so all of
      // it is reset; only the PC resets to a nonzero value.
      pay_q    <= '0;
      pay_q.pc <= RESET_PC;
      tnew_q   <= '0;
`ifdef DE_REG_VALID_EN
      valid_q  <= 1'b0;
`endif
    end else begin
      pay_q    <= pay_d;
      tnew_q   <= tnew_d;
`ifdef DE_REG_VALID_EN
      valid_q  <= valid_d;
`endif
    end
  end

  assign E_PC       = pay_q.pc;
  assign E_Instr    = pay_q.instr;
  assign E_RS_Data  = pay_q.rs_data;
  assign E_RT_Data  = pay_q.rt_data;
  assign E_Ext_Imm  = pay_q.ext_imm;
  assign E_WriteReg = pay_q.write_reg;
  assign E_Tnew     = tnew_q;
  assign E_ExcCode  = pay_q.exc_code;
  assign E_BD       = pay_q.bd;
`ifdef DE_REG_VALID_EN
  assign E_Valid    = valid_q;
`endif

endmodule

// File: tb/tb_de_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_de_pipe_reg
// Self-checking bench for de_pipe_reg. Directed scenarios followed by a
// randomized run compared against a behavioural model of the register.
// Honours DE_REG_VALID_EN for the optional E_Valid output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_de_pipe_reg;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, stall;
  logic [31:0] D_PC, D_Instr, D_RS_Data, D_RT_Data, D_Ext_Imm;
  logic [4:0]  D_WriteReg, D_ExcCode;
  logic [1:0]  D_Tnew;
  logic        D_BD;
  logic [31:0] E_PC, E_Instr, E_RS_Data, E_RT_Data, E_Ext_Imm;
  logic [4:0]  E_WriteReg, E_ExcCode;
  logic [1:0]  E_Tnew;
  logic        E_BD;
`ifdef DE_REG_VALID_EN
  logic        E_Valid;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: what E should hold after the coming edge.
  logic [31:0] exp_pc, exp_instr, exp_rs, exp_rt, exp_imm;
  logic [4:0]  exp_wr, exp_exc;
  logic [1:0]  exp_tnew;
  logic        exp_bd, exp_valid;

  always #5 clk = ~clk;

  de_pipe_reg dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .stall      (stall),
    .D_PC       (D_PC),
    .D_Instr    (D_Instr),
    .D_RS_Data  (D_RS_Data),
    .D_RT_Data  (D_RT_Data),
    .D_Ext_Imm  (D_Ext_Imm),
    .D_WriteReg (D_WriteReg),
    .D_Tnew     (D_Tnew),
    .D_ExcCode  (D_ExcCode),
    .D_BD       (D_BD),
    .E_PC       (E_PC),
    .E_Instr    (E_Instr),
    .E_RS_Data  (E_RS_Data),
    .E_RT_Data  (E_RT_Data),
    .E_Ext_Imm  (E_Ext_Imm),
    .E_WriteReg (E_WriteReg),
    .E_Tnew     (E_Tnew),
    .E_ExcCode  (E_ExcCode),
    .E_BD       (E_BD)
`ifdef DE_REG_VALID_EN
    ,
    .E_Valid    (E_Valid)
`endif
  );

  // Behavioural model: the three cases of the register, written from the
  // stage rules. Tnew is "cycles remaining", one fewer one stage later, floor 0.
  task automatic model_edge();
    int t;
    exp_pc = 32'h0; exp_instr = 32'h0; exp_rs = 32'h0; exp_rt = 32'h0;
    exp_imm = 32'h0; exp_wr = 5'd0; exp_exc = 5'd0; exp_tnew = 2'd0;
    exp_bd = 1'b0; exp_valid = 1'b0;
    if (req) begin
      exp_pc = 32'h0000_4180;
    end else if (stall) begin
      exp_pc = D_PC;
      exp_bd = D_BD;
    end else begin
      t = int'(D_Tnew) - 1;
      if (t < 0) t = 0;
      exp_pc = D_PC; exp_instr = D_Instr; exp_rs = D_RS_Data;
      exp_rt = D_RT_Data; exp_imm = D_Ext_Imm; exp_wr = D_WriteReg;
      exp_exc = D_ExcCode; exp_tnew = 2'(t); exp_bd = D_BD; exp_valid = 1'b1;
    end
  endtask

  task automatic clear_inputs();
    req = 1'b0; stall = 1'b0;
    D_PC = 32'h0; D_Instr = 32'h0; D_RS_Data = 32'h0; D_RT_Data = 32'h0;
    D_Ext_Imm = 32'h0; D_WriteReg = 5'd0; D_Tnew = 2'd0; D_ExcCode = 5'd0;
    D_BD = 1'b0;
  endtask

  task automatic randomize_d();
    D_PC = $urandom; D_Instr = $urandom; D_RS_Data = $urandom;
    D_RT_Data = $urandom; D_Ext_Imm = $urandom;
    D_WriteReg = 5'($urandom); D_Tnew = 2'($urandom);
    D_ExcCode = 5'($urandom); D_BD = 1'($urandom);
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Load nonzero state, then drop reset mid-cycle: outputs clear at once.
    @(negedge clk);
    reset_n = 1'b1;
    randomize_d();
    D_WriteReg = 5'd17; D_Instr = 32'h1234_5678; D_Tnew = 2'd3; D_BD = 1'b1;
    tick();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (E_PC !== 32'h0000_3000) begin
      errors++; $display("FAIL reset_pc: got %h want %h", E_PC, 32'h0000_3000);
    end
    checks++;
    if ({E_Instr, E_RS_Data, E_RT_Data, E_Ext_Imm, E_WriteReg, E_Tnew, E_ExcCode, E_BD} !== '0) begin
      errors++; $display("FAIL reset_zero: instr=%h wr=%0d tnew=%0d bd=%b want all 0",
                         E_Instr, E_WriteReg, E_Tnew, E_BD);
    end
`ifdef DE_REG_VALID_EN
    checks++;
    if (E_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", E_Valid);
    end
`endif
    // Reset held across an edge with req and stall asserted still wins.
    req = 1'b1; stall = 1'b1;
    tick();
    checks++;
    if (E_PC !== 32'h0000_3000 || E_WriteReg !== 5'd0) begin
      errors++; $display("FAIL reset_over_req: pc=%h wr=%0d want pc=00003000 wr=0", E_PC, E_WriteReg);
    end
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_normal();
    @(negedge clk);
    clear_inputs();
    D_PC = 32'h0000_3004; D_WriteReg = 5'd8; D_Tnew = 2'd2; D_RS_Data = 32'hDEAD_BEEF;
    D_RT_Data = 32'h0BAD_F00D; D_Instr = 32'h0123_4567; D_Ext_Imm = 32'hFFFF_FFF0;
    tick();
    checks++;
    if (E_PC !== 32'h0000_3004) begin
      errors++; $display("FAIL normal_pc: got %h want %h", E_PC, 32'h0000_3004);
    end
    checks++;
    if (E_WriteReg !== 5'd8) begin
      errors++; $display("FAIL normal_wr: got %0d want 8", E_WriteReg);
    end
    checks++;
    if (E_Tnew !== 2'd1) begin
      errors++; $display("FAIL normal_tnew: got %0d want 1", E_Tnew);
    end
    checks++;
    if (E_RS_Data !== 32'hDEAD_BEEF || E_RT_Data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL normal_ops: rs=%h rt=%h want deadbeef 0badf00d", E_RS_Data, E_RT_Data);
    end
    checks++;
    if (E_Instr !== 32'h0123_4567 || E_Ext_Imm !== 32'hFFFF_FFF0) begin
      errors++; $display("FAIL normal_instr_imm: instr=%h imm=%h want 01234567 fffffff0", E_Instr, E_Ext_Imm);
    end
`ifdef DE_REG_VALID_EN
    checks++;
    if (E_Valid !== 1'b1) begin
      errors++; $display("FAIL normal_valid: got %b want 1", E_Valid);
    end
`endif
  endtask

  task automatic test_bubble();
    @(negedge clk);
    randomize_d();
    stall = 1'b1; D_PC = 32'h0000_3010; D_BD = 1'b1; D_WriteReg = 5'd31; D_Tnew = 2'd3;
    tick();
    checks++;
    if (E_PC !== 32'h0000_3010 || E_BD !== 1'b1) begin
      errors++; $display("FAIL bubble_pc_bd: pc=%h bd=%b want 00003010 1", E_PC, E_BD);
    end
    checks++;
    if (E_WriteReg !== 5'd0 || E_Instr !== 32'h0 || E_Tnew !== 2'd0) begin
      errors++; $display("FAIL bubble_zero: wr=%0d instr=%h tnew=%0d want 0 0 0", E_WriteReg, E_Instr, E_Tnew);
    end
    checks++;
    if ({E_RS_Data, E_RT_Data, E_Ext_Imm, E_ExcCode} !== '0) begin
      errors++; $display("FAIL bubble_ops: rs=%h rt=%h imm=%h exc=%0d want 0", E_RS_Data, E_RT_Data, E_Ext_Imm, E_ExcCode);
    end
`ifdef DE_REG_VALID_EN
    checks++;
    if (E_Valid !== 1'b0) begin
      errors++; $display("FAIL bubble_valid: got %b want 0", E_Valid);
    end
`endif
  endtask

  task automatic test_flush();
    @(negedge clk);
    randomize_d();
    req = 1'b1; stall = 1'b1; D_ExcCode = EXC_RI; D_BD = 1'b1; D_WriteReg = 5'd9;
    tick();
    checks++;
    if (E_PC !== 32'h0000_4180) begin
      errors++; $display("FAIL flush_pc: got %h want %h", E_PC, 32'h0000_4180);
    end
    checks++;
    if (E_ExcCode !== 5'd0 || E_BD !== 1'b0 || E_WriteReg !== 5'd0) begin
      errors++; $display("FAIL flush_state: exc=%0d bd=%b wr=%0d want 0 0 0", E_ExcCode, E_BD, E_WriteReg);
    end
    checks++;
    if ({E_Instr, E_RS_Data, E_RT_Data, E_Ext_Imm, E_Tnew} !== '0) begin
      errors++; $display("FAIL flush_data: instr=%h rs=%h tnew=%0d want 0", E_Instr, E_RS_Data, E_Tnew);
    end
    @(negedge clk);
    req = 1'b0; stall = 1'b0;
  endtask

  task automatic test_tnew_sat();
    logic [1:0] want [4];
    want[0] = 2'd0; want[1] = 2'd0; want[2] = 2'd1; want[3] = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      D_PC = 32'h0000_3020 + 32'(4 * i);
      D_Tnew = 2'(i);
      tick();
      checks++;
      if (E_Tnew !== want[i]) begin
        errors++; $display("FAIL tnew_sat[%0d]: got %0d want %0d", i, E_Tnew, want[i]);
      end
    end
  endtask

  task automatic test_exc_carry();
    @(negedge clk);
    clear_inputs();
    D_PC = 32'h0000_3040; D_ExcCode = EXC_SYSCALL; D_WriteReg = 5'd2;
    tick();
    checks++;
    if (E_ExcCode !== 5'd8) begin
      errors++; $display("FAIL exc_code: got %0d want 8", E_ExcCode);
    end
    checks++;
    if (E_PC !== 32'h0000_3040) begin
      errors++; $display("FAIL exc_pc: got %h want %h", E_PC, 32'h0000_3040);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      randomize_d();
      req   = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      model_edge();
      tick();
      checks++;
      if ({E_PC, E_Instr, E_RS_Data, E_RT_Data, E_Ext_Imm, E_WriteReg, E_Tnew, E_ExcCode, E_BD} !==
          {exp_pc, exp_instr, exp_rs, exp_rt, exp_imm, exp_wr, exp_tnew, exp_exc, exp_bd}) begin
        errors++;
        $display("FAIL random[%0d] req=%b stall=%b: got pc=%h wr=%0d tnew=%0d exc=%0d bd=%b instr=%h want pc=%h wr=%0d tnew=%0d exc=%0d bd=%b instr=%h",
                 n, req, stall, E_PC, E_WriteReg, E_Tnew, E_ExcCode, E_BD, E_Instr,
                 exp_pc, exp_wr, exp_tnew, exp_exc, exp_bd, exp_instr);
      end
`ifdef DE_REG_VALID_EN
      checks++;
      if (E_Valid !== exp_valid) begin
        errors++; $display("FAIL random_valid[%0d]: got %b want %b", n, E_Valid, exp_valid);
      end
`endif
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_normal();
    test_bubble();
    test_flush();
    test_tnew_sat();
    test_exc_carry();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
